crc_receiver: RTL and testbench

CRC_RECEIVER -- requirements
Module: crc_receiver

---
 rtl/crc_receiver.sv | 174 +++++++++++++++++
 tb/tb_crc_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_receiver.sv
// crc_receiver: serial MSB-first frame receiver. A frame is DATA_W payload
// bits followed by CRC_W CRC bits, sampled only where enable is high. The CRC
// is accumulated over the payload while it arrives. When the last CRC bit is
// sampled, the payload, the received CRC, the computed CRC and a match flag are
// registered together with a one-cycle valid pulse. A frame stalled for GAP_MAX
// idle cycles is dropped with a one-cycle abort pulse.
module crc_receiver #(
    parameter int unsigned      DATA_W    = 128,
    parameter int unsigned      CRC_W     = 32,
    parameter logic [CRC_W-1:0] POLY      = 32'h04C11DB7,
    parameter logic [CRC_W-1:0] INIT      = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0] FINAL_XOR = 32'h0,
    parameter int unsigned      GAP_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out,
    output logic [CRC_W-1:0]  crc_rx,
    output logic [CRC_W-1:0]  crc_calc,
    output logic              valid,
    output logic              crc_ok,
    output logic              abort,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + CRC_W);
    localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + CRC_W - 1);
    localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic [CRC_W-1:0]  crc_q,      crc_d;
    logic [DATA_W-1:0] pay_q,      pay_d;
    logic [CRC_W-1:0]  cap_q,      cap_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [CRC_W-1:0]  crc_rx_q,   crc_rx_d;
    logic [CRC_W-1:0]  crc_calc_q, crc_calc_d;
    logic              crc_ok_q,   crc_ok_d;
    logic              valid_q,    valid_d;
    logic              abort_q,    abort_d;

    logic [CRC_W-1:0]  cap_full;
    logic [CRC_W-1:0]  crc_final;
    logic [GAP_W-1:0]  gap_nxt;

    // One MSB-first LFSR step of the CRC register for input bit b.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic             b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Next-state logic: frame sequencing, CRC accumulation, gap timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        crc_d      = crc_q;
        pay_d      = pay_q;
        cap_d      = cap_q;
        data_d     = data_q;
        crc_rx_d   = crc_rx_q;
        crc_calc_d = crc_calc_q;
        crc_ok_d   = crc_ok_q;
        valid_d    = 1'b0;
        abort_d    = 1'b0;

        cap_full  = {cap_q[CRC_W-2:0], serial};
        crc_final = crc_q ^ FINAL_XOR;
        gap_nxt   = gap_q + GAP_W'(1);

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    // INIT is folded in here so the first bit sees it directly.
                    crc_d   = crc_step(INIT, serial);
                    pay_d   = {pay_q[DATA_W-2:0], serial};
                    cnt_d   = CNT_W'(1);
                    gap_d   = '0;
                    state_d = S_PAYLOAD;
                end
            end

            S_PAYLOAD, S_CHECK: begin
                if (enable) begin
                    gap_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == S_PAYLOAD) begin
                        crc_d = crc_step(crc_q, serial);
                        pay_d = {pay_q[DATA_W-2:0], serial};
                        if (cnt_q == LAST_PAY) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        cap_d = cap_full;
                        if (cnt_q == LAST_BIT) begin
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                            valid_d    = 1'b1;
                            data_d     = pay_q;
                            crc_rx_d   = cap_full;
                            crc_calc_d = crc_final;
                            crc_ok_d   = (cap_full == crc_final);
                        end
                    end
                end else if (gap_nxt == GAP_LIM) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gap_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    gap_d = gap_nxt;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            crc_q      <= '0;
            pay_q      <= '0;
            cap_q      <= '0;
            data_q     <= '0;
            crc_rx_q   <= '0;
            crc_calc_q <= '0;
            crc_ok_q   <= 1'b0;
            valid_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            crc_q      <= crc_d;
            pay_q      <= pay_d;
            cap_q      <= cap_d;
            data_q     <= data_d;
            crc_rx_q   <= crc_rx_d;
            crc_calc_q <= crc_calc_d;
            crc_ok_q   <= crc_ok_d;
            valid_q    <= valid_d;
            abort_q    <= abort_d;
        end
    end

    assign data_out = data_q;
    assign crc_rx   = crc_rx_q;
    assign crc_calc = crc_calc_q;
    assign crc_ok   = crc_ok_q;
    assign valid    = valid_q;
    assign abort    = abort_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_crc_receiver.sv
// Testbench for crc_receiver: a 72-bit-payload instance and a default
// instance, each checked every cycle against a frame-level reference model,
// plus directed literal expectations.
module tb_crc_receiver;

    localparam int GAP_MAX = 16;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] INIT = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst_n;
    logic en72, s72, en128, s128;

    logic [71:0]  d72;
    logic [31:0]  rx72, calc72;
    logic         v72, ok72, ab72, busy72;
    logic [127:0] d128;
    logic [31:0]  rx128, calc128;
    logic         v128, ok128, ab128, busy128;

    always #5 clk = ~clk;

    crc_receiver #(.DATA_W(72)) u72 (
        .clk(clk), .rst(rst_n), .serial(s72), .enable(en72),
        .data_out(d72), .crc_rx(rx72), .crc_calc(calc72),
        .valid(v72), .crc_ok(ok72), .abort(ab72), .busy(busy72)
    );

    crc_receiver u128 (
        .clk(clk), .rst(rst_n), .serial(s128), .enable(en128),
        .data_out(d128), .crc_rx(rx128), .crc_calc(calc128),
        .valid(v128), .crc_ok(ok128), .abort(ab128), .busy(busy128)
    );

    // CRC as the remainder of (M * x^32 + INIT * x^dw) divided by {1,POLY}.
    function automatic logic [31:0] crc_of(input logic [127:0] p, input int dw);
        logic [159:0] m;
        m = 160'(p) << 32;
        m = m ^ (160'(INIT) << dw);
        for (int i = dw + 31; i >= 32; i--) begin
            if (m[i]) m = m ^ (160'({1'b1, POLY}) << (i - 32));
        end
        return m[31:0];
    endfunction

    typedef struct {
        logic         inframe;
        int           cnt;
        int           gap;
        logic [159:0] bits;
        logic [127:0] data;
        logic [31:0]  crc_rx;
        logic [31:0]  crc_calc;
        logic         ok;
        logic         valid;
        logic         abort;
    } model_t;

    // Frame-level reference: collect sampled bits, evaluate at frame end.
    function automatic model_t mnext(input model_t m, input logic r, input logic e,
                                     input logic s, input int dw);
        model_t n;
        n = m;
        n.valid = 1'b0;
        n.abort = 1'b0;
        if (!r) begin
            n.inframe = 1'b0; n.cnt = 0; n.gap = 0; n.bits = '0;
            n.data = '0; n.crc_rx = '0; n.crc_calc = '0; n.ok = 1'b0;
        end else if (e) begin
            n.bits = {m.bits[158:0], s};
            n.cnt = m.cnt + 1;
            n.gap = 0;
            n.inframe = 1'b1;
            if (n.cnt == dw + 32) begin
                n.data = 128'(n.bits >> 32);
                n.crc_rx = n.bits[31:0];
                n.crc_calc = crc_of(n.data, dw);
                n.ok = (n.crc_rx == n.crc_calc);
                n.valid = 1'b1;
                n.inframe = 1'b0; n.cnt = 0; n.bits = '0;
            end
        end else if (m.inframe) begin
            n.gap = m.gap + 1;
            if (n.gap == GAP_MAX) begin
                n.abort = 1'b1;
                n.inframe = 1'b0; n.cnt = 0; n.gap = 0; n.bits = '0;
            end
        end
        return n;
    endfunction

    model_t m0, m1;

    // Advance both reference models on the same edge the DUTs sample.
    always @(posedge clk) begin
        m0 <= mnext(m0, rst_n, en72, s72, 72);
        m1 <= mnext(m1, rst_n, en128, s128, 128);
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int nv1 = 0, nok1 = 0, nab1 = 0, tv_prev = 0, tv_last = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("u72.valid",     128'(v72),    128'(m0.valid));
        chk("u72.abort",     128'(ab72),   128'(m0.abort));
        chk("u72.busy",      128'(busy72), 128'(m0.inframe));
        chk("u72.data_out",  128'(d72),    m0.data);
        chk("u72.crc_rx",    128'(rx72),   128'(m0.crc_rx));
        chk("u72.crc_calc",  128'(calc72), 128'(m0.crc_calc));
        chk("u72.crc_ok",    128'(ok72),   128'(m0.ok));
        chk("u128.valid",    128'(v128),   128'(m1.valid));
        chk("u128.abort",    128'(ab128),  128'(m1.abort));
        chk("u128.busy",     128'(busy128),128'(m1.inframe));
        chk("u128.data_out", d128,         m1.data);
        chk("u128.crc_rx",   128'(rx128),  128'(m1.crc_rx));
        chk("u128.crc_calc", 128'(calc128),128'(m1.crc_calc));
        chk("u128.crc_ok",   128'(ok128),  128'(m1.ok));
    endtask

    task automatic drive(input int inst, input logic e, input logic s);
        @(negedge clk);
        if (inst == 0) begin en72 = e; s72 = s; end
        else begin en128 = e; s128 = s; end
    endtask

    // Serialise the first nbits of {payload, crc}, MSB first, optionally
    // inserting gap_len idle cycles before bit gap_at.
    task automatic send(input int inst, input logic [127:0] p, input int dw,
                        input logic [31:0] c, input int nbits, input int gap_at,
                        input int gap_len, input bit stop);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) drive(inst, 1'b0, 1'b0);
            end
            b = (i < dw) ? p[dw-1-i] : c[31-(i-dw)];
            drive(inst, 1'b1, b);
        end
        if (stop) drive(inst, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p9, pa, pb, pc, pd, pe;
        int snap_v, snap_ok, snap_ab;
        p9 = 128'h313233343536373839;
        pa = 128'h73713cb13141af131d313d3231398810;
        pb = 128'h0123456789abcdeffedcba9876543210;
        pc = 128'hdeadbeefcafef00d0badc0de12345678;
        pd = 128'h5555aaaa3333cccc0f0ff0f0ffff0000;
        pe = 128'h80000000000000000000000000000001;

        rst_n = 1'b0; en72 = 1'b0; s72 = 1'b0; en128 = 1'b0; s128 = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (chk_en) begin
                    compare_all();
                    if (v128) begin
                        nv1++;
                        tv_prev = tv_last;
                        tv_last = cyc;
                        if (ok128) nok1++;
                    end
                    if (ab128) nab1++;
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy",     128'(busy128), 128'(0));
        chk("reset data_out", d128,          128'(0));
        chk("reset crc_calc", 128'(calc72),  128'(0));
        chk("reset valid",    128'(v72),     128'(0));
        rst_n = 1'b1;

        chk("model crc 123456789", 128'(crc_of(p9, 72)), 128'h0376E6E7);

        // Good 72-bit frame.
        send(0, p9, 72, 32'h0376E6E7, 104, -1, 0, 1'b1);
        chk("good valid",    128'(v72),    128'(1));
        chk("good crc_ok",   128'(ok72),   128'(1));
        chk("good crc_calc", 128'(calc72), 128'h0376E6E7);
        chk("good data_out", 128'(d72),    128'h313233343536373839);
        repeat (3) @(negedge clk);

        // Same frame with CRC bit 0 flipped.
        send(0, p9, 72, 32'h0376E6E6, 104, -1, 0, 1'b1);
        chk("bad valid",    128'(v72),    128'(1));
        chk("bad crc_ok",   128'(ok72),   128'(0));
        chk("bad crc_rx",   128'(rx72),   128'h0376E6E6);
        chk("bad crc_calc", 128'(calc72), 128'h0376E6E7);
        repeat (3) @(negedge clk);

        // Back-to-back default frames.
        snap_v = nv1; snap_ok = nok1;
        send(1, pa, 128, crc_of(pa, 128), 160, -1, 0, 1'b0);
        send(1, pb, 128, crc_of(pb, 128), 160, -1, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("b2b valid count",   128'(nv1 - snap_v),      128'(2));
        chk("b2b valid spacing", 128'(tv_last - tv_prev), 128'(160));
        chk("b2b crc_ok count",  128'(nok1 - snap_ok),    128'(2));
        chk("b2b data_out",      d128,                    pb);

        // Gap of GAP_MAX-1 idle cycles is tolerated.
        send(1, pc, 128, crc_of(pc, 128), 160, 60, GAP_MAX - 1, 1'b1);
        chk("gap15 valid",  128'(v128),  128'(1));
        chk("gap15 crc_ok", 128'(ok128), 128'(1));
        repeat (2) @(negedge clk);

        // Gap of GAP_MAX idle cycles aborts the frame.
        snap_v = nv1; snap_ab = nab1;
        send(1, pd, 128, crc_of(pd, 128), 40, -1, 0, 1'b1);
        repeat (GAP_MAX + 4) @(negedge clk);
        chk("abort count",         128'(nab1 - snap_ab), 128'(1));
        chk("abort no valid",      128'(nv1 - snap_v),   128'(0));
        chk("abort busy",          128'(busy128),        128'(0));
        chk("abort data held",     d128,                 pc);
        chk("abort crc_ok held",   128'(ok128),          128'(1));

        // Reset in mid-payload, then a full frame.
        snap_v = nv1; snap_ab = nab1;
        send(1, pe, 128, crc_of(pe, 128), 50, -1, 0, 1'b0);
        @(negedge clk); rst_n = 1'b0; en128 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rst busy",     128'(busy128), 128'(0));
        chk("rst data_out", d128,          128'(0));
        chk("rst crc_rx",   128'(rx128),   128'(0));
        chk("rst crc_ok",   128'(ok128),   128'(0));
        send(1, pe, 128, crc_of(pe, 128), 160, -1, 0, 1'b1);
        chk("post-rst valid",    128'(v128),  128'(1));
        chk("post-rst crc_ok",   128'(ok128), 128'(1));
        chk("post-rst data_out", d128,        pe);
        repeat (3) @(negedge clk);
        chk("rst no abort", 128'(nab1 - snap_ab), 128'(0));
        chk("rst one valid", 128'(nv1 - snap_v),  128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
